// File: rtl/awb_axis_tx.sv
// AXI4-Stream transmit adapter for the AWB delay path: rebuilds SOF/EOL framing
// from beat counters and buffers the free-running input through a FIFO.
module awb_axis_tx #(
  parameter int IMG_WIDTH    = 1920,
  parameter int IMG_HEIGHT   = 1080,
  parameter int DATA_WIDTH   = 96,
  parameter int PIX_PER_BEAT = 4,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_valid,
  input  logic [DATA_WIDTH-1:0] I_data,
  input  logic                  I_tuser,
  output logic                  O_tvalid,
  input  logic                  I_tready,
  output logic [DATA_WIDTH-1:0] O_tdata,
  output logic                  O_tuser,
  output logic                  O_tlast,
  output logic                  O_overflow,
  output logic                  O_sof_err
);

  localparam int BEATS = IMG_WIDTH / PIX_PER_BEAT;
  localparam int HW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = DATA_WIDTH + 2;

  typedef enum logic [0:0] {WAIT_SOF, RUN} state_t;

  // Input side has no backpressure: every I_valid beat is either written or dropped.
  // Output side: a beat transfers on a clock edge where O_tvalid && I_tready; once
  // O_tvalid is high the stream outputs hold until that transfer happens.

  state_t                  state_q, state_d;
  logic [HW-1:0]           h_q, h_d, beat_h;
  logic [VW-1:0]           v_q, v_d, beat_v;
  logic                    sof_pending_q;
  logic                    in_valid_q, in_sof_q;
  logic [DATA_WIDTH-1:0]   in_data_q;
  logic                    wr_req, wr_en, rd_en, ovf_hit, sof_err_hit;
  logic                    tag_sof, tag_eol;
  logic [EW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q;
  logic                    fifo_full, fifo_empty;
  logic                    out_valid_q, out_sof_q, out_eol_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic                    overflow_q, sof_err_q;

  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign rd_en      = !fifo_empty && (!out_valid_q || I_tready);

  // An early I_tuser is remembered and attached to the next valid beat.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      in_valid_q    <= 1'b0;
      in_sof_q      <= 1'b0;
      in_data_q     <= '0;
      sof_pending_q <= 1'b0;
    end else begin
      in_valid_q <= I_valid;
      in_data_q  <= I_data;
      in_sof_q   <= I_valid && (I_tuser || sof_pending_q);
      if (I_valid)
        sof_pending_q <= 1'b0;
      else if (I_tuser)
        sof_pending_q <= 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q <= WAIT_SOF;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    beat_h      = h_q;
    beat_v      = v_q;
    wr_req      = 1'b0;
    sof_err_hit = 1'b0;
    ovf_hit     = 1'b0;
    if (in_valid_q) begin
      if (state_q == WAIT_SOF) begin
        if (in_sof_q) begin
          wr_req = 1'b1;
          beat_h = '0;
          beat_v = '0;
        end
      end else begin
        wr_req = 1'b1;
        if (in_sof_q && (h_q != '0 || v_q != '0)) begin
          sof_err_hit = 1'b1;
          beat_h      = '0;
          beat_v      = '0;
        end
      end
    end
    tag_sof = (beat_h == '0) && (beat_v == '0);
    tag_eol = (beat_h == HW'(BEATS-1));
    if (wr_req) begin
      if (fifo_full && !rd_en) begin
        // Lost beat breaks the frame; resync on the next SOF.
        ovf_hit = 1'b1;
        state_d = WAIT_SOF;
        h_d     = '0;
        v_d     = '0;
      end else begin
        state_d = RUN;
        if (tag_eol) begin
          h_d = '0;
          v_d = (beat_v == VW'(IMG_HEIGHT-1)) ? '0 : beat_v + VW'(1);
        end else begin
          h_d = beat_h + HW'(1);
          v_d = beat_v;
        end
      end
    end
  end

  assign wr_en = wr_req && !ovf_hit;

  always_ff @(posedge I_clk) begin
    if (wr_en)
      mem[wr_ptr_q] <= {tag_sof, tag_eol, in_data_q};
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_data_q  <= '0;
    end else if (!out_valid_q || I_tready) begin
      out_valid_q <= !fifo_empty;
      if (!fifo_empty) begin
        {out_sof_q, out_eol_q, out_data_q} <= mem[rd_ptr_q];
      end else begin
        out_sof_q <= 1'b0;
        out_eol_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      overflow_q <= 1'b0;
      sof_err_q  <= 1'b0;
    end else begin
      if (ovf_hit) overflow_q <= 1'b1;
      sof_err_q <= sof_err_hit;
    end
  end

  assign O_tvalid   = out_valid_q;
  assign O_tdata    = out_data_q;
  assign O_tuser    = out_sof_q;
  assign O_tlast    = out_eol_q;
  assign O_overflow = overflow_q;
  assign O_sof_err  = sof_err_q;

endmodule

// File: tb/tb_awb_axis_tx.sv
// Directed bench for awb_axis_tx with a small frame (4 beats x 2 lines) and a
// 4-entry FIFO; expected beats are hand-listed into a scoreboard queue.
module tb_awb_axis_tx;

  localparam int DW = 16;

  logic          I_clk = 1'b0;
  logic          I_rst_n = 1'b0;
  logic          I_valid = 1'b0;
  logic          I_tuser = 1'b0;
  logic          I_tready = 1'b0;
  logic [DW-1:0] I_data = '0;
  logic          O_tvalid, O_tuser, O_tlast, O_overflow, O_sof_err;
  logic [DW-1:0] O_tdata;

  awb_axis_tx #(
    .IMG_WIDTH(16), .IMG_HEIGHT(2), .DATA_WIDTH(DW), .PIX_PER_BEAT(4), .FIFO_DEPTH(4)
  ) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_valid(I_valid), .I_data(I_data),
    .I_tuser(I_tuser), .O_tvalid(O_tvalid), .I_tready(I_tready), .O_tdata(O_tdata),
    .O_tuser(O_tuser), .O_tlast(O_tlast), .O_overflow(O_overflow), .O_sof_err(O_sof_err)
  );

  // Clock / cycle counter
  always #5 I_clk = ~I_clk;
  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  int            errors = 0;
  int            checks = 0;
  logic [DW+1:0] exp_q[$];
  int            hs_cyc_q[$];
  int            sof_err_cnt = 0;
  bit            bp_mode = 1'b0;
  int            t0, base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Driver tasks: inputs change only 1 time unit after a rising edge.
  task automatic cycle(input logic v, input logic u, input logic [DW-1:0] d);
    I_valid = v;
    I_tuser = u;
    I_data  = d;
    if (bp_mode) I_tready = ~I_tready;
    @(posedge I_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    I_rst_n = 1'b0;
    cycle(1'b0, 1'b0, '0);
    I_rst_n = 1'b1;
  endtask

  task automatic resync();
    @(posedge I_clk);
    #1;
  endtask

  task automatic expect_beat(input logic sof, input logic eol, input logic [DW-1:0] d);
    exp_q.push_back({sof, eol, d});
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle(1'b0, 1'b0, '0);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Scoreboard / monitor: sampled on the falling edge.
  logic          pv = 1'b0, pr = 1'b0;
  logic [DW+1:0] pbeat = '0;
  initial begin
    forever begin
      @(negedge I_clk);
      if (I_rst_n) begin
        if (pv && !pr)
          check("hold_stable", {O_tvalid, O_tuser, O_tlast, O_tdata}, {1'b1, pbeat});
        if (O_sof_err) sof_err_cnt++;
        if (O_tvalid && I_tready) begin
          hs_cyc_q.push_back(cyc);
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_beat: observed=%0h expected=none", {O_tuser, O_tlast, O_tdata});
          end
          if (exp_q.size() != 0)
            check("beat", {O_tuser, O_tlast, O_tdata}, exp_q.pop_front());
        end
      end
      pv    = I_rst_n && O_tvalid;
      pr    = I_tready;
      pbeat = {O_tuser, O_tlast, O_tdata};
    end
  end

  initial begin
    // Reset state
    do_reset();
    @(negedge I_clk);
    check("rst_tvalid", O_tvalid, 0);
    check("rst_tuser", O_tuser, 0);
    check("rst_tlast", O_tlast, 0);
    check("rst_tdata", O_tdata, 0);
    check("rst_overflow", O_overflow, 0);
    check("rst_sof_err", O_sof_err, 0);
    resync();

    // Nominal frame, I_tready held high
    I_tready = 1'b1;
    exp_q.delete();
    hs_cyc_q.delete();
    base = sof_err_cnt;
    expect_beat(1, 0, 16'h1000); expect_beat(0, 0, 16'h1001);
    expect_beat(0, 0, 16'h1002); expect_beat(0, 1, 16'h1003);
    expect_beat(0, 0, 16'h1004); expect_beat(0, 0, 16'h1005);
    expect_beat(0, 0, 16'h1006); expect_beat(0, 1, 16'h1007);
    cycle(1, 1, 16'h1000);
    t0 = cyc;
    for (int i = 1; i < 8; i++) cycle(1, 0, 16'h1000 + 16'(i));
    drain("nominal", 20);
    check("nominal_count", hs_cyc_q.size(), 8);
    check("nominal_latency", (hs_cyc_q.size() > 0) ? hs_cyc_q[0] - t0 : -1, 2);
    check("nominal_back_to_back", (hs_cyc_q.size() >= 8) ? hs_cyc_q[7] - hs_cyc_q[0] : -1, 7);
    check("nominal_no_sof_err", sof_err_cnt - base, 0);

    // Early tuser after garbage beats
    do_reset();
    exp_q.delete();
    hs_cyc_q.delete();
    expect_beat(1, 0, 16'h2000); expect_beat(0, 0, 16'h2001);
    expect_beat(0, 0, 16'h2002); expect_beat(0, 1, 16'h2003);
    cycle(1, 0, 16'hBAD0);
    cycle(1, 0, 16'hBAD1);
    cycle(0, 1, 16'h0000);
    idle(2);
    for (int i = 0; i < 4; i++) cycle(1, 0, 16'h2000 + 16'(i));
    drain("early_tuser", 20);
    check("early_tuser_count", hs_cyc_q.size(), 4);

    // Backpressure: I_tready toggles every cycle
    do_reset();
    exp_q.delete();
    hs_cyc_q.delete();
    expect_beat(1, 0, 16'h3000); expect_beat(0, 0, 16'h3001);
    expect_beat(0, 0, 16'h3002); expect_beat(0, 1, 16'h3003);
    expect_beat(0, 0, 16'h3004); expect_beat(0, 0, 16'h3005);
    expect_beat(0, 0, 16'h3006); expect_beat(0, 1, 16'h3007);
    I_tready = 1'b1;
    bp_mode  = 1'b1;
    cycle(1, 1, 16'h3000);
    for (int i = 1; i < 8; i++) cycle(1, 0, 16'h3000 + 16'(i));
    drain("backpressure", 40);
    bp_mode  = 1'b0;
    I_tready = 1'b1;
    check("backpressure_count", hs_cyc_q.size(), 8);
    check("backpressure_no_overflow", O_overflow, 0);

    // Overflow: 7 beats with I_tready low; 5 survive
    do_reset();
    exp_q.delete();
    hs_cyc_q.delete();
    I_tready = 1'b0;
    expect_beat(1, 0, 16'h4000); expect_beat(0, 0, 16'h4001);
    expect_beat(0, 0, 16'h4002); expect_beat(0, 1, 16'h4003);
    expect_beat(0, 0, 16'h4004);
    cycle(1, 1, 16'h4000);
    for (int i = 1; i < 7; i++) cycle(1, 0, 16'h4000 + 16'(i));
    idle(3);
    @(negedge I_clk);
    check("ovf_flag", O_overflow, 1);
    check("ovf_head_valid", O_tvalid, 1);
    check("ovf_head_data", O_tdata, 16'h4000);
    resync();
    I_tready = 1'b1;
    drain("ovf", 20);
    idle(6);
    check("ovf_drain_count", hs_cyc_q.size(), 5);
    hs_cyc_q.delete();
    expect_beat(1, 0, 16'h5000); expect_beat(0, 0, 16'h5001);
    expect_beat(0, 0, 16'h5002); expect_beat(0, 1, 16'h5003);
    expect_beat(0, 0, 16'h5004); expect_beat(0, 0, 16'h5005);
    expect_beat(0, 0, 16'h5006); expect_beat(0, 1, 16'h5007);
    cycle(1, 1, 16'h5000);
    for (int i = 1; i < 8; i++) cycle(1, 0, 16'h5000 + 16'(i));
    drain("ovf_next_frame", 20);
    check("ovf_next_frame_count", hs_cyc_q.size(), 8);
    check("ovf_sticky", O_overflow, 1);

    // Mid-frame SOF
    do_reset();
    exp_q.delete();
    hs_cyc_q.delete();
    I_tready = 1'b1;
    base = sof_err_cnt;
    expect_beat(1, 0, 16'h6000); expect_beat(0, 0, 16'h6001);
    expect_beat(1, 0, 16'h7000); expect_beat(0, 0, 16'h7001);
    expect_beat(0, 0, 16'h7002); expect_beat(0, 1, 16'h7003);
    cycle(1, 1, 16'h6000);
    cycle(1, 0, 16'h6001);
    cycle(1, 1, 16'h7000);
    for (int i = 1; i < 4; i++) cycle(1, 0, 16'h7000 + 16'(i));
    drain("midsof", 20);
    idle(2);
    check("midsof_err_pulses", sof_err_cnt - base, 1);
    check("midsof_count", hs_cyc_q.size(), 6);

    // Reset mid-frame
    do_reset();
    exp_q.delete();
    I_tready = 1'b0;
    cycle(1, 1, 16'h8000);
    cycle(1, 0, 16'h8001);
    cycle(1, 0, 16'h8002);
    idle(2);
    @(negedge I_clk);
    check("midrst_pre_valid", O_tvalid, 1);
    resync();
    do_reset();
    @(negedge I_clk);
    check("midrst_tvalid", O_tvalid, 0);
    check("midrst_tuser", O_tuser, 0);
    check("midrst_tdata", O_tdata, 0);
    resync();
    I_tready = 1'b1;
    idle(3);
    @(negedge I_clk);
    check("midrst_fifo_empty", O_tvalid, 0);
    resync();
    hs_cyc_q.delete();
    for (int i = 0; i < 4; i++) cycle(1, 0, 16'h9000 + 16'(i));
    idle(8);
    check("midrst_no_sof_ignored", hs_cyc_q.size(), 0);
    check("midrst_final_tvalid", O_tvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
